// File: rtl/board_store.sv
// board_store
//   Authoritative 64-square chess board. Accepts square-change commands from
//   the user state machine, loads the opening position on reset and on every
//   game (re)start, and reports captures, king loss and a half-move count.
//
//   Square encoding: bit3 = colour (0 white, 1 black), bits2:0 = type
//   (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 reserved).
//   Address: addr[5:3] = column a..h, addr[2:0] = row, row 0 at the top.
//
//   Handshake: change_piece[10] is a level-sensitive write strobe with no
//   ready; every cycle it is high is one write request. Requests are only
//   honoured while board_ready is high and no restart is being taken in the
//   same cycle; otherwise they are discarded.
//
//   Optional feature (macro BOARD_WRITE_GUARD_EN): suppress writes that would
//   not change the square, and add a write_dropped pulse for every discarded
//   write request.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   change_piece   [5:0] address, [9:6] new content, [10] write enable
//   game_state     user-state-machine state; START_STATE requests a reload
//   entire_board   packed board, square a in bits [4a+3:4a]
//   board_ready    high once the opening position is loaded
//   capture_valid  one-cycle pulse after a capturing write
//   captured_piece content removed by the most recent capture
//   king_lost      sticky; [0] white king taken, [1] black king taken
//   move_count     saturating count of source-square clears
//   write_dropped  (BOARD_WRITE_GUARD_EN only) pulse per discarded write
//   state_dbg      current FSM state (0 INIT, 1 RUN)
module board_store #(
  parameter int          COUNT_W     = 10,
  parameter logic [2:0]  START_STATE = 3'b000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [10:0]        change_piece,
  input  logic [2:0]         game_state,
  output logic [255:0]       entire_board,
  output logic               board_ready,
  output logic               capture_valid,
  output logic [3:0]         captured_piece,
  output logic [1:0]         king_lost,
  output logic [COUNT_W-1:0] move_count,
`ifdef BOARD_WRITE_GUARD_EN
  output logic               write_dropped,
`endif
  output logic               state_dbg
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [5:0]     idx_q;
  logic [255:0]   board_q;

  logic           wr_en;
  logic [5:0]     wr_addr;
  logic [3:0]     wr_data;
  logic [3:0]     old_data;
  logic           restart;
  logic           guard_hit;
  logic           do_write;
  logic           is_capture;
  logic           is_clear;

  // Opening content of a square; the white back rank is the black one with
  // the colour bit cleared.
  function automatic logic [3:0] opening(input logic [5:0] a);
    logic [2:0] back;
    logic [3:0] v;
    case (a[5:3])
      3'd0, 3'd7: back = 3'd4;
      3'd1, 3'd6: back = 3'd2;
      3'd2, 3'd5: back = 3'd3;
      3'd3:       back = 3'd5;
      default:    back = 3'd6;
    endcase
    case (a[2:0])
      3'd0:    v = {1'b1, back};
      3'd1:    v = 4'h9;
      3'd6:    v = 4'h1;
      3'd7:    v = {1'b0, back};
      default: v = 4'h0;
    endcase
    return v;
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (idx_q == 6'd63) state_d = S_RUN;
      S_RUN:   if (game_state == START_STATE) state_d = S_INIT;
      default: state_d = S_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    board_ready = (state_q == S_RUN);
    state_dbg   = state_q;
  end

  // ---------------- write decode ----------------
  always_comb begin
    wr_en     = change_piece[10];
    wr_data   = change_piece[9:6];
    wr_addr   = change_piece[5:0];
    old_data  = board_q[{wr_addr, 2'b00} +: 4];
    restart   = (state_q == S_RUN) && (game_state == START_STATE);
`ifdef BOARD_WRITE_GUARD_EN
    guard_hit = (state_q == S_RUN) && wr_en && !restart && (wr_data == old_data);
`else
    guard_hit = 1'b0;
`endif
    do_write  = (state_q == S_RUN) && wr_en && !restart && !guard_hit;
    // Capture: both old and new occupied and of opposite colours.
    is_capture = do_write && (old_data[2:0] != 3'd0) && (wr_data[2:0] != 3'd0)
                 && (old_data[3] != wr_data[3]);
    // Completed move: a piece lifted off its source square.
    is_clear   = do_write && (wr_data == 4'h0) && (old_data[2:0] != 3'd0);
  end

  // ---------------- board storage and init index ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      board_q <= '0;
      idx_q   <= '0;
    end else begin
      if (state_q == S_INIT) begin
        board_q[{idx_q, 2'b00} +: 4] <= opening(idx_q);
        idx_q <= idx_q + 6'd1;   // wraps to 0 as the last square is loaded
      end else if (do_write) begin
        board_q[{wr_addr, 2'b00} +: 4] <= wr_data;
      end
      if (restart) idx_q <= '0;
    end
  end

  // ---------------- status ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_valid  <= 1'b0;
      captured_piece <= '0;
      king_lost      <= '0;
      move_count     <= '0;
    end else begin
      capture_valid <= is_capture;
      if (restart) begin
        captured_piece <= '0;
        king_lost      <= '0;
        move_count     <= '0;
      end else begin
        if (is_capture) begin
          captured_piece <= old_data;
          if (old_data[2:0] == 3'd6) king_lost[old_data[3]] <= 1'b1;
        end
        if (is_clear && (move_count != {COUNT_W{1'b1}}))
          move_count <= move_count + COUNT_W'(1);
      end
    end
  end

`ifdef BOARD_WRITE_GUARD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) write_dropped <= 1'b0;
    else          write_dropped <= wr_en && ((state_q == S_INIT) || restart || guard_hit);
  end
`endif

  assign entire_board = board_q;

endmodule

// File: tb/tb_board_store.sv
module tb_board_store;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [10:0]  change_piece;
  logic [2:0]   game_state;

  logic [255:0] entire_board, sat_board;
  logic         board_ready, sat_ready;
  logic         capture_valid, sat_cv;
  logic [3:0]   captured_piece, sat_cp;
  logic [1:0]   king_lost, sat_kl;
  logic [9:0]   move_count;
  logic [1:0]   sat_mc;
  logic         state_dbg, sat_state;
`ifdef BOARD_WRITE_GUARD_EN
  logic         write_dropped, sat_wd;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] exp_open;

  board_store #(.COUNT_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .change_piece(change_piece), .game_state(game_state),
    .entire_board(entire_board), .board_ready(board_ready), .capture_valid(capture_valid),
    .captured_piece(captured_piece), .king_lost(king_lost), .move_count(move_count),
`ifdef BOARD_WRITE_GUARD_EN
    .write_dropped(write_dropped),
`endif
    .state_dbg(state_dbg)
  );

  board_store #(.COUNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .change_piece(change_piece), .game_state(game_state),
    .entire_board(sat_board), .board_ready(sat_ready), .capture_valid(sat_cv),
    .captured_piece(sat_cp), .king_lost(sat_kl), .move_count(sat_mc),
`ifdef BOARD_WRITE_GUARD_EN
    .write_dropped(sat_wd),
`endif
    .state_dbg(sat_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sq(input logic [255:0] b, input int a);
    return b[a*4 +: 4];
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Presents one write and lets one edge take it; enable is left high so
  // back-to-back calls produce consecutive enabled cycles.
  task automatic write_sq(input logic [5:0] addr, input logic [3:0] data);
    change_piece = {1'b1, data, addr};
    tick();
  endtask

  task automatic idle();
    change_piece = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] back_b [8];
    back_b = '{4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC};
    exp_open = '0;
    for (int c = 0; c < 8; c++) begin
      exp_open[(c*8 + 0)*4 +: 4] = back_b[c];
      exp_open[(c*8 + 1)*4 +: 4] = 4'h9;
      exp_open[(c*8 + 6)*4 +: 4] = 4'h1;
      exp_open[(c*8 + 7)*4 +: 4] = back_b[c] & 4'h7;
    end

    reset_n      = 1'b0;
    change_piece = '0;
    game_state   = 3'b001;
    ticks(2);
    check("rst_board", entire_board, '0);
    check("rst_ready", board_ready, 0);
    check("rst_cv", capture_valid, 0);
    check("rst_cp", captured_piece, 0);
    check("rst_kl", king_lost, 0);
    check("rst_mc", move_count, 0);
    check("rst_state", state_dbg, 0);

    // Opening load: 64 edges after release.
    reset_n = 1'b1;
    ticks(63);
    check("init_ready_63", board_ready, 0);
    tick();
    check("init_ready_64", board_ready, 1);
    check("init_state", state_dbg, 1);
    check("init_sq00", sq(entire_board, 8'h00), 4'hC);
    check("init_sq26", sq(entire_board, 8'h26), 4'h1);
    check("init_sq27", sq(entire_board, 8'h27), 4'h6);
    check("init_sq04", sq(entire_board, 8'h04), 4'h0);
    check("init_board", entire_board, exp_open);
    check("init_mc", move_count, 0);

    // Pawn move e2-e4 style: destination, then source clear.
    write_sq(6'h24, 4'h1);
    check("pawn_cv1", capture_valid, 0);
    write_sq(6'h26, 4'h0);
    check("pawn_cv2", capture_valid, 0);
    check("pawn_dst_seen", sq(entire_board, 8'h24), 4'h1);
    idle();
    tick();
    check("pawn_cv3", capture_valid, 0);
    check("pawn_sq24", sq(entire_board, 8'h24), 4'h1);
    check("pawn_sq26", sq(entire_board, 8'h26), 4'h0);
    check("pawn_mc", move_count, 1);

    // Capture of a black pawn by a white pawn.
    write_sq(6'h1B, 4'h9);
    check("cap_place_cv", capture_valid, 0);
    write_sq(6'h1B, 4'h1);
    check("cap_cv", capture_valid, 1);
    check("cap_piece", captured_piece, 4'h9);
    check("cap_kl", king_lost, 2'b00);
    idle();
    tick();
    check("cap_cv_pulse", capture_valid, 0);
    check("cap_piece_held", captured_piece, 4'h9);
    check("cap_mc", move_count, 1);

    // White rook takes the black king.
    write_sq(6'h20, 4'h4);
    check("king_cv", capture_valid, 1);
    check("king_piece", captured_piece, 4'hE);
    check("king_kl", king_lost, 2'b10);
    idle();

    // Same-colour overwrite: stored, but not a capture.
    write_sq(6'h21, 4'hA);
    check("same_cv", capture_valid, 0);
    idle();
    tick();
    check("same_sq21", sq(entire_board, 8'h21), 4'hA);
    check("same_piece", captured_piece, 4'hE);

    // Clears: 0x24, 0x1B, 0x04 (already empty), 0x20, 0x00.
    write_sq(6'h24, 4'h0);
    write_sq(6'h1B, 4'h0);
    check("clr_mc3", move_count, 3);
    check("clr_sat3", sat_mc, 3);
    write_sq(6'h04, 4'h0);
    check("clr_empty_mc", move_count, 3);
    write_sq(6'h20, 4'h0);
    write_sq(6'h00, 4'h0);
    idle();
    tick();
    check("clr_mc5", move_count, 5);
    check("clr_sat_mc", sat_mc, 2'd3);
    check("king_sticky", king_lost, 2'b10);

    // Restart with a colliding write to an empty square.
    game_state   = 3'b000;
    change_piece = {1'b1, 4'h5, 6'h2A};
    tick();
    game_state = 3'b001;
    idle();
    check("rs_ready", board_ready, 0);
    check("rs_sq2A", sq(entire_board, 8'h2A), 4'h0);
    check("rs_mc", move_count, 0);
    check("rs_kl", king_lost, 0);
    check("rs_cp", captured_piece, 0);
`ifdef BOARD_WRITE_GUARD_EN
    check("rs_dropped", write_dropped, 1);
`endif
    ticks(10);
    write_sq(6'h00, 4'h5);          // during INIT: must be ignored
    idle();
    ticks(29);
    game_state = 3'b000;            // during INIT: must not restart
    tick();
    game_state = 3'b001;
    ticks(22);                      // 63 edges after the restart edge
    check("rs_ready_63", board_ready, 0);
    tick();
    check("rs_ready_64", board_ready, 1);
    check("rs_board", entire_board, exp_open);
    check("rs_sat_mc", sat_mc, 0);

    // Reset while the reload is at square 30.
    game_state = 3'b000;
    tick();
    game_state = 3'b001;
    ticks(30);
    reset_n = 1'b0;
    #1;
    check("mid_rst_board", entire_board, '0);
    check("mid_rst_ready", board_ready, 0);
    tick();
    reset_n = 1'b1;
    ticks(63);
    check("mid_ready_63", board_ready, 0);
    tick();
    check("mid_ready_64", board_ready, 1);
    check("mid_board", entire_board, exp_open);
    check("mid_mc", move_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Write-side sink for the 11-bit square-change command bus produced by the user state machine.
- Holds the authoritative 64-square board and drives the 256-bit packed board back to the move logic and the VGA renderer.
- Loads the opening position on reset and on every game (re)start.
- Reports captures, king loss and a half-move count.

Parameters:
- COUNT_W, 10, width of move_count; saturating.
- START_STATE, 3'b000, game_state encoding that requests a board (re)initialisation.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- change_piece  input  11  [5:0] square address, [9:6] new content, [10] write enable (level; one write per cycle while high)
- game_state  input  3  current user-state-machine state
- entire_board  output  256  square a occupies bits [4a+3:4a]
- board_ready  output  1  high when the init sequence is done and writes are accepted
- capture_valid  output  1  one-cycle pulse on a capturing write
- captured_piece  output  4  content overwritten by the last capture; held until the next capture or init
- king_lost  output  2  sticky; [0] white king captured, [1] black king captured
- move_count  output  COUNT_W  completed moves (source-square clears)

Behaviour:
- Square encoding:
  - bit3 = colour (0 white, 1 black).
  - bits2:0 = type: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 reserved (stored as-is).
- Address mapping: addr[5:3] = column 0..7 (a..h); addr[2:0] = row 0..7 with row 0 at the top.
- Opening position:
  - Row 0: black R N B Q K B N R for cols 0..7 (0xC,0xA,0xB,0xD,0xE,0xB,0xA,0xC).
  - Row 1: black pawns (0x9).
  - Row 6: white pawns (0x1).
  - Row 7: white R N B Q K B N R (0x4,0x2,0x3,0x5,0x6,0x3,0x2,0x4).
  - All other squares 0.
- FSM states: INIT, RUN.
- Reset (async, reset_n=0):
  - Board all zero; board_ready=0; capture_valid=0; captured_piece=0; king_lost=0; move_count=0.
  - State=INIT, init index=0.
- INIT:
  - Each cycle writes the opening value to square[index]; index increments.
  - After square 63 is written: state=RUN, board_ready=1 on the next cycle. Total 64 cycles from reset release.
  - On entry, king_lost, captured_piece and move_count are cleared.
  - change_piece writes are ignored.
  - game_state==START_STATE during INIT does not restart the sequence.
- RUN:
  - game_state==START_STATE → INIT with index 0 next cycle; board_ready=0 next cycle. A write presented in the same cycle is dropped.
  - change_piece[10]=1 → square[addr] <= content at that edge. entire_board reflects it the following cycle (1-cycle latency; no bypass).
  - Consecutive enabled cycles with different addr/content each perform a write. Typical: destination write, then source clear.
- Capture detection (RUN, enabled write):
  - Condition: old square type != 0, new type != 0, and old colour != new colour.
  - Then capture_valid=1 for one cycle after the edge, and captured_piece=old content.
  - If old type = 6: king_lost[old colour] <= 1 (sticky).
  - Same-colour overwrite: written, not a capture.
- move_count:
  - Increments when an enabled write of content 0 hits a square with nonzero old type.
  - Saturates at 2^COUNT_W-1.
  - A clear of an already empty square does not count.
- No other state changes; reserved type 7 is never treated as a king.

Optional Feature:
- Macro BOARD_WRITE_GUARD_EN.
- Defined:
  - In RUN, an enabled write whose new content equals the current square content is suppressed: no capture, no count.
  - Output write_dropped (1 bit, reset 0) pulses one cycle for each write dropped for any reason: guard, INIT, or restart collision.
- Undefined: all in-RUN writes performed as above; write_dropped port absent.

Test Plan:
- Release reset, wait 64 clk → board_ready=1; square 0=0xC, square 0x26 (col4,row6)=0x1, square 0x27=0x6, square 0x04=0x0; move_count=0.
- Move pawn 0x26→0x24: write {en,0x1,0x24}, then {en,0x0,0x26}, then en=0 → 0x24=0x1, 0x26=0, move_count=1, capture_valid never high.
- Capture: set 0x1B=0x9, then write {en,0x1,0x1B} → capture_valid pulses once, captured_piece=0x9, king_lost=00.
- King capture: write {en,0x4,0x20} onto black king (0x20=0xE) → captured_piece=0xE, king_lost=2'b10; remains set until game_state=000.
- Restart: in RUN, drive game_state=000 for one cycle with a simultaneous write → write lost, board_ready low for 64 cycles, opening position restored, move_count=0, king_lost=0.
- Reset mid-INIT (reset_n low at index 30) → board zero immediately; after release, full 64-cycle init completes; saturate check: COUNT_W=2 with 5 clears → move_count=3.
